// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The FSM states, the funct3 access-size encodings and the byte-enable width
// live here so the top and the alignment helper agree on them.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // Unlisted funct3 codes (011/110/111) behave as a full word.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

    // Halfwords must sit on an even address, words on a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SZ_H:    is_misaligned = a[0];
            SZ_W:    is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit.
// Purely combinational: builds store byte enables and lane-replicated write data,
// and pulls the addressed byte/half out of a read word with sign or zero extension.
// Halfwords always use offset {a[1],0} and words offset 0, so a misaligned access
// that is not trapped simply lands on the enclosing aligned lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    lsu_size_t  size;
    logic [1:0] lane;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    // Select lanes from the access size, then steer store data and extract load data.
    always_comb begin
        size      = f3_size(funct3);
        lane      = 2'b00;
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_B: begin
                lane  = offset;
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                lane  = {offset[1], 1'b0};
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                lane = 2'b00;
            end
        endcase
        ld_byte = rdata[{lane, 3'b000} +: 8];
        ld_half = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    load_data = funct3[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                           : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            SZ_H:    load_data = funct3[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                           : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage after the RV32I ALU: one load or store at a time over a
// req/gnt/rvalid data-memory handshake, with extended load data to writeback.
// Optional feature: define MISALIGN_TRAP_EN to drop misaligned halfword/word
// accesses and pulse 'misalign' instead; undefined, misalign is tied low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] alu_rslt,
    input  logic [XLEN-1:0] store_data,
    input  logic [RD_W-1:0] ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            misalign
);

    lsu_state_t      state, state_next;
    logic [2:0]      op_funct3;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_data;
    logic [RD_W-1:0] op_rd;
    logic            op_is_load;
    logic            take;
    logic            trap;
    logic [BE_W-1:0] align_be;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;

    assign ex_ready = (state == IDLE);
    assign stall    = (state != IDLE);
    assign take     = ex_valid && ex_ready && (ex_is_load || ex_is_store);

`ifdef MISALIGN_TRAP_EN
    assign trap = take && is_misaligned(ex_funct3, alu_rslt[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (op_funct3),
        .offset     (op_addr[1:0]),
        .store_data (op_data),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept -> request -> (loads only) wait for read data.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (take && !trap) state_next = REQ;
            REQ:  if (dmem_gnt)      state_next = op_is_load ? WAIT : IDLE;
            WAIT: if (dmem_rvalid)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Capture the accepted operation so the request stays stable until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct3  <= '0;
            op_addr    <= '0;
            op_data    <= '0;
            op_rd      <= '0;
            op_is_load <= 1'b0;
        end else if (take) begin
            op_funct3  <= ex_funct3;
            op_addr    <= alu_rslt;
            op_data    <= store_data;
            op_rd      <= ex_rd;
            op_is_load <= ex_is_load;
        end
    end

    // Memory request outputs, driven only while a request is outstanding.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        if (state == REQ) begin
            dmem_req   = 1'b1;
            dmem_we    = !op_is_load;
            dmem_addr  = {op_addr[XLEN-1:2], 2'b00};
            dmem_be    = align_be;
            dmem_wdata = align_wdata;
        end
    end

    // Register the extended load result and pulse wb_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= (state == WAIT) && dmem_rvalid;
            if ((state == WAIT) && dmem_rvalid) begin
                wb_rd   <= op_rd;
                wb_data <= align_load;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // One-cycle pulse after a dropped misaligned access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= trap;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// A transaction-level model follows accepted ops and predicts every output at each
// falling edge; directed sequences pin the model with hand-computed literals, then
// a randomized phase exercises ops, handshake timing and occasional resets.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready;
    logic            ex_is_load = 1'b0;
    logic            ex_is_store = 1'b0;
    logic [2:0]      ex_funct3 = '0;
    logic [XLEN-1:0] alu_rslt = '0;
    logic [XLEN-1:0] store_data = '0;
    logic [RD_W-1:0] ex_rd = '0;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt = 1'b0;
    logic            dmem_rvalid = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic            misalign;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .alu_rslt(alu_rslt), .store_data(store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .misalign(misalign)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                                 input logic g, input logic rv, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        ex_valid    = v;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        alu_rslt    = a;
        store_data  = d;
        ex_rd       = rd;
        dmem_gnt    = g;
        dmem_rvalid = rv;
        dmem_rdata  = rdat;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int m_offset(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz == 1) return int'(a % 4);
        if (sz == 2) return int'(a % 4) & 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        return 4'(((1 << sz) - 1) << m_offset(f3, a));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = m_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        int sz = m_size(f3);
        logic [31:0] v;
        logic [31:0] span;
        v = rdat >> (8 * m_offset(f3, a));
        if (sz == 4) return v;
        span = 32'd1 << (8 * sz);
        v = v % span;
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    // ---------------- transaction model and per-cycle compare ----------------
    bit          m_busy, m_granted, m_wb, m_mis, m_is_load, nx_wb, nx_mis, exp_req;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_data, m_wb_data;
    logic [4:0]  m_rd, m_wb_rd;

    initial begin
        m_busy = 0; m_granted = 0; m_wb = 0; m_mis = 0; m_is_load = 0;
        m_f3 = '0; m_addr = '0; m_data = '0; m_rd = '0; m_wb_data = '0; m_wb_rd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst ex_ready", 32'(ex_ready), 32'd1);
                checkOutput("rst stall", 32'(stall), 32'd0);
                checkOutput("rst dmem_req", 32'(dmem_req), 32'd0);
                checkOutput("rst dmem_we", 32'(dmem_we), 32'd0);
                checkOutput("rst dmem_addr", dmem_addr, 32'd0);
                checkOutput("rst dmem_be", 32'(dmem_be), 32'd0);
                checkOutput("rst dmem_wdata", dmem_wdata, 32'd0);
                checkOutput("rst wb_valid", 32'(wb_valid), 32'd0);
                checkOutput("rst wb_rd", 32'(wb_rd), 32'd0);
                checkOutput("rst wb_data", wb_data, 32'd0);
                checkOutput("rst misalign", 32'(misalign), 32'd0);
                m_busy = 0; m_granted = 0; m_wb = 0; m_mis = 0;
            end else begin
                exp_req = m_busy && !m_granted;
                checkOutput("ex_ready", 32'(ex_ready), 32'(!m_busy));
                checkOutput("stall", 32'(stall), 32'(m_busy));
                checkOutput("dmem_req", 32'(dmem_req), 32'(exp_req));
                checkOutput("dmem_we", 32'(dmem_we), 32'(exp_req && !m_is_load));
                checkOutput("dmem_addr", dmem_addr, exp_req ? (m_addr & ~32'd3) : 32'd0);
                checkOutput("dmem_be", 32'(dmem_be), exp_req ? 32'(m_be(m_f3, m_addr)) : 32'd0);
                checkOutput("dmem_wdata", dmem_wdata, exp_req ? m_wdata(m_f3, m_data) : 32'd0);
                checkOutput("wb_valid", 32'(wb_valid), 32'(m_wb));
                if (m_wb) begin
                    checkOutput("wb_data", wb_data, m_wb_data);
                    checkOutput("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                end
                checkOutput("misalign", 32'(misalign), 32'(m_mis));
                nx_wb = 0;
                nx_mis = 0;
                if (!m_busy) begin
                    if (ex_valid && (ex_is_load || ex_is_store)) begin
                        if (TRAP_EN && m_misaligned(ex_funct3, alu_rslt)) begin
                            nx_mis = 1;
                        end else begin
                            m_busy = 1; m_granted = 0; m_is_load = ex_is_load;
                            m_f3 = ex_funct3; m_addr = alu_rslt; m_data = store_data; m_rd = ex_rd;
                        end
                    end
                end else if (!m_granted) begin
                    if (dmem_gnt) begin
                        if (m_is_load) m_granted = 1;
                        else m_busy = 0;
                    end
                end else if (dmem_rvalid) begin
                    nx_wb = 1;
                    m_wb_data = m_load(m_f3, m_addr, dmem_rdata);
                    m_wb_rd = m_rd;
                    m_busy = 0;
                end
                m_wb = nx_wb;
                m_mis = nx_mis;
            end
        end
    end

    // ---------------- directed then random stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycle();

        // SW a=0x100, granted in its first request cycle.
        applyStimulus(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
        @(negedge clk);
        checkOutput("sw req", 32'(dmem_req), 32'd1);
        checkOutput("sw we", 32'(dmem_we), 32'd1);
        checkOutput("sw addr", dmem_addr, 32'h100);
        checkOutput("sw be", 32'(dmem_be), 32'hF);
        checkOutput("sw wdata", dmem_wdata, 32'hDEADBEEF);
        idleCycle();
        @(negedge clk);
        checkOutput("sw ready back", 32'(ex_ready), 32'd1);
        checkOutput("sw no wb", 32'(wb_valid), 32'd0);

        // LB / LBU a=0x103 with rdata 0x80000000.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, 0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'd0, 5'd7, 0, 0, 32'd0);
            applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
            applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 1, 32'h80000000);
            idleCycle();
            @(negedge clk);
            checkOutput("lb wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("lb wb_data", wb_data, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
            checkOutput("lb wb_rd", 32'(wb_rd), 32'd7);
            idleCycle();
            @(negedge clk);
            checkOutput("lb wb pulse end", 32'(wb_valid), 32'd0);
        end

        // SH a=0x102 d=0x1234.
        applyStimulus(1, 0, 1, 3'b001, 32'h102, 32'h00001234, 5'd0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
        @(negedge clk);
        checkOutput("sh be", 32'(dmem_be), 32'hC);
        checkOutput("sh wdata", dmem_wdata, 32'h12341234);
        idleCycle();

        // LW with grant held off for three cycles.
        applyStimulus(1, 1, 0, 3'b010, 32'h200, 32'd0, 5'd9, 0, 0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            idleCycle();
            @(negedge clk);
            checkOutput("lw hold req", 32'(dmem_req), 32'd1);
            checkOutput("lw hold addr", dmem_addr, 32'h200);
            checkOutput("lw hold be", 32'(dmem_be), 32'hF);
            checkOutput("lw hold stall", 32'(stall), 32'd1);
            checkOutput("lw hold ready", 32'(ex_ready), 32'd0);
        end
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 1, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("lw wb early", 32'(wb_valid), 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("lw wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("lw wb_data", wb_data, 32'hCAFEF00D);
        checkOutput("lw wb_rd", 32'(wb_rd), 32'd9);
        idleCycle();
        @(negedge clk);
        checkOutput("lw wb pulse end", 32'(wb_valid), 32'd0);

        // LW a=0x101: trapped with the feature, otherwise issued to the aligned word.
        applyStimulus(1, 1, 0, 3'b010, 32'h101, 32'd0, 5'd3, 0, 0, 32'd0);
        idleCycle();
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis pulse", 32'(misalign), 32'd1);
        checkOutput("mis no req", 32'(dmem_req), 32'd0);
`else
        checkOutput("mis off addr", dmem_addr, 32'h100);
        checkOutput("mis off be", 32'(dmem_be), 32'hF);
        checkOutput("mis off flag", 32'(misalign), 32'd0);
`endif
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 1, 32'h01020304);
        idleCycle();
        idleCycle();

        // Reset while waiting for read data; a late rvalid must be ignored.
        applyStimulus(1, 1, 0, 3'b010, 32'h300, 32'd0, 5'd5, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1, 0, 32'd0);
        idleCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwait stall", 32'(stall), 32'd0);
        checkOutput("rstwait ready", 32'(ex_ready), 32'd1);
        checkOutput("rstwait req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 1, 32'hFFFFFFFF);
        @(negedge clk);
        checkOutput("rstwait late rvalid", 32'(wb_valid), 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("rstwait no wb", 32'(wb_valid), 32'd0);
        checkOutput("rstwait idle", 32'(ex_ready), 32'd1);

        // Randomized ops, handshake timing and sporadic resets.
        $display("[TB] random phase");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
        repeat (3) idleCycle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
